// File: rtl/morse_playback_if.sv
// Handshake/bus bundle for morse_playback. The abort input exists only when MORSE_ABORT_EN is defined.
`timescale 1ns/1ps
interface morse_playback_if #(
    parameter int NUM_SLOTS = 16,
    parameter int SEQ_W     = 10
);
    logic                         start;
    logic [NUM_SLOTS*SEQ_W-1:0]   i_sequence;
    logic                         tone_out;
    logic                         busy;
    logic                         done;
    logic [$clog2(NUM_SLOTS)-1:0] slot_idx;
`ifdef MORSE_ABORT_EN
    logic                         abort;

    modport master (output start, i_sequence, abort,
                    input  tone_out, busy, done, slot_idx);
    modport slave  (input  start, i_sequence, abort,
                    output tone_out, busy, done, slot_idx);
`else
    modport master (output start, i_sequence,
                    input  tone_out, busy, done, slot_idx);
    modport slave  (input  start, i_sequence,
                    output tone_out, busy, done, slot_idx);
`endif
endinterface

// File: rtl/morse_playback.sv
// Keys a snapshot of the 16x10-bit letter store out as Morse on tone_out, oldest slot first; abort input under MORSE_ABORT_EN.
// First tone rises 1 + (leading empty slots) cycles after start; start is ignored while busy (no backpressure).
`timescale 1ns/1ps
module morse_playback #(
    parameter int CLK_PER_UNIT = 4,
    parameter int NUM_SLOTS    = 16,
    parameter int SEQ_W        = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    morse_playback_if.slave       bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int ELEMS  = SEQ_W / 2;
    localparam int CNT_W  = $clog2(3 * CLK_PER_UNIT + 1);

    localparam logic [CNT_W-1:0]  DOT_M1    = CNT_W'(CLK_PER_UNIT - 1);
    localparam logic [CNT_W-1:0]  DASH_M1   = CNT_W'(3 * CLK_PER_UNIT - 1);
    localparam logic [CNT_W-1:0]  LGAP_M1   = CNT_W'(2 * CLK_PER_UNIT - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [2:0]        PTR_LAST  = 3'(ELEMS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ELEM_ON = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_LGAP    = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    logic [2:0]                 r_state;
    logic [NUM_SLOTS*SEQ_W-1:0] r_shadow;
    logic [SLOT_W-1:0]          r_slot;
    logic [2:0]                 r_ptr;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_tone;

    logic [2:0]        w_nxt_state;
    logic [SLOT_W-1:0] w_nxt_slot;
    logic [2:0]        w_nxt_ptr;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic              w_load;
    logic [SEQ_W-1:0]  w_cur;
    logic [1:0]        w_first_code;
    logic [1:0]        w_nxt_code;
    logic              w_has_next;

    // Element k sits in bits [SEQ_W-1-2k -: 2]; MSB pair is played first.
    function automatic logic [1:0] f_code(input logic [SEQ_W-1:0] s, input logic [2:0] p);
        logic [1:0] c;
        c = 2'b00;
        for (int k = 0; k < ELEMS; k++) begin
            if (p == 3'(k)) c = s[SEQ_W-1-2*k -: 2];
        end
        return c;
    endfunction

    function automatic logic f_is_elem(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction

    function automatic logic [CNT_W-1:0] f_dur(input logic [1:0] c);
        return (c == 2'b10) ? DASH_M1 : DOT_M1;
    endfunction

    assign w_cur        = r_shadow[r_slot*SEQ_W +: SEQ_W];
    assign w_first_code = f_code(w_cur, 3'd0);
    // Pointer is clamped so the lookahead never reaches past bit 0 after the last element.
    assign w_nxt_code   = f_code(w_cur, (r_ptr == PTR_LAST) ? PTR_LAST : r_ptr + 3'd1);
    assign w_has_next   = (r_ptr != PTR_LAST) && f_is_elem(w_nxt_code);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_slot  = r_slot;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_nxt_slot  = SLOT_LAST;
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!f_is_elem(w_first_code)) begin
                    if (r_slot == '0) w_nxt_state = S_FIN;
                    else              w_nxt_slot  = r_slot - 1'b1;
                end else begin
                    w_nxt_ptr   = 3'd0;
                    w_nxt_cnt   = f_dur(w_first_code);
                    w_nxt_state = S_ELEM_ON;
                end
            end
            S_ELEM_ON: begin
                if (r_cnt == '0) begin
                    w_nxt_cnt   = DOT_M1;
                    w_nxt_state = S_GAP;
                end else begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end else if (w_has_next) begin
                    w_nxt_ptr   = r_ptr + 3'd1;
                    w_nxt_cnt   = f_dur(w_nxt_code);
                    w_nxt_state = S_ELEM_ON;
                end else begin
                    w_nxt_cnt   = LGAP_M1;
                    w_nxt_state = S_LGAP;
                end
            end
            S_LGAP: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end else if (r_slot == '0) begin
                    w_nxt_state = S_FIN;
                end else begin
                    w_nxt_slot  = r_slot - 1'b1;
                    w_nxt_state = S_FETCH;
                end
            end
            S_FIN:   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
`ifdef MORSE_ABORT_EN
        if (bus.abort && (r_state != S_IDLE) && (r_state != S_FIN)) begin
            w_nxt_state = S_FIN;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_slot  <= '1;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_tone  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_slot  <= w_nxt_slot;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= w_nxt_cnt;
            r_tone  <= (w_nxt_state == S_ELEM_ON);
        end
    end

    // Snapshot is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_load) r_shadow <= bus.i_sequence;
    end

    assign bus.tone_out = r_tone;
    assign bus.busy     = (r_state != S_IDLE) && (r_state != S_FIN);
    assign bus.done     = (r_state == S_FIN);
    assign bus.slot_idx = r_slot;

endmodule

// File: tb/tb_morse_playback.sv
// Bench for morse_playback: directed and random letter stores checked cycle by cycle against a timeline model.
`timescale 1ns/1ps
module tb_morse_playback;
    localparam int U = 4;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    int   exp_tone[$];
    int   exp_slot[$];

    morse_playback_if #(.NUM_SLOTS(16), .SEQ_W(10)) bus ();

    morse_playback #(.CLK_PER_UNIT(U), .NUM_SLOTS(16), .SEQ_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic push(input int v, input int n, input int slot);
        for (int i = 0; i < n; i++) begin
            exp_tone.push_back(v);
            exp_slot.push_back(slot);
        end
    endtask

    // Timeline from the playback rules: one scan cycle per slot, then per element
    // on-time plus one unit off, then two more units off after each letter.
    task automatic build(input logic [159:0] seq);
        logic [9:0] s;
        logic [1:0] c;
        bit         stop;
        exp_tone.delete();
        exp_slot.delete();
        for (int k = 15; k >= 0; k--) begin
            s = seq[k*10 +: 10];
            push(0, 1, k);
            stop = 0;
            for (int e = 0; e < 5; e++) begin
                c = s[9-2*e -: 2];
                if (!stop && (c == 2'b01 || c == 2'b10)) begin
                    push(1, (c == 2'b01) ? U : 3*U, k);
                    push(0, U, k);
                end else begin
                    stop = 1;
                end
            end
            if (s[9:8] == 2'b01 || s[9:8] == 2'b10) push(0, 2*U, k);
        end
    endtask

    // Caller sits at a negedge; start is raised there and sampled on the next posedge.
    task automatic play(input logic [159:0] seq, input int inj_at, input logic [159:0] alt, input int rst_at);
        int len;
        build(seq);
        len = exp_tone.size();
        bus.i_sequence = seq;
        bus.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 0; t <= len; t++) begin
            if (t == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_tone", t, 32'(bus.tone_out), 0);
                chk("rst_busy", t, 32'(bus.busy), 0);
                chk("rst_done", t, 32'(bus.done), 0);
                chk("rst_slot", t, 32'(bus.slot_idx), 32'hF);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    chk("rst_quiet_done", t + i, 32'(bus.done), 0);
                    chk("rst_quiet_tone", t + i, 32'(bus.tone_out), 0);
                end
                return;
            end
            if (t < len) begin
                chk("tone", t, 32'(bus.tone_out), 32'(exp_tone[t]));
                chk("slot", t, 32'(bus.slot_idx), 32'(exp_slot[t]));
                chk("busy", t, 32'(bus.busy), 1);
                chk("done_early", t, 32'(bus.done), 0);
            end else begin
                chk("done", t, 32'(bus.done), 1);
                chk("busy_at_done", t, 32'(bus.busy), 0);
                chk("tone_at_done", t, 32'(bus.tone_out), 0);
            end
            if (t == inj_at) begin
                bus.start      = 1'b1;
                bus.i_sequence = alt;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_single", len + 1, 32'(bus.done), 0);
        chk("busy_after", len + 1, 32'(bus.busy), 0);
    endtask

    function automatic logic [9:0] rand_slot();
        logic [9:0] s;
        int         n;
        s = 10'($urandom);
        if ($urandom_range(0, 2) == 0) begin
            s[9:8] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            return s;
        end
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) s[9-2*i -: 2] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        if (n < 5) s[9-2*n -: 2] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        return s;
    endfunction

    initial begin
        logic [159:0] seq;
        logic [159:0] alt;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.i_sequence = '0;
`ifdef MORSE_ABORT_EN
        bus.abort      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_tone", 0, 32'(bus.tone_out), 0);
        chk("reset_busy", 0, 32'(bus.busy), 0);
        chk("reset_done", 0, 32'(bus.done), 0);
        chk("reset_slot", 0, 32'(bus.slot_idx), 32'hF);

        // "E" in the last-played slot
        seq = '1;
        seq[9:0] = 10'b0111111111;
        play(seq, -1, '0, -1);

        // "A" in the oldest slot, started the cycle after the previous done
        seq = '1;
        seq[159:150] = 10'b0110111111;
        play(seq, -1, '0, -1);

        // Same "A" with a second start mid-letter carrying a different store
        alt = '0;
        alt[159:150] = 10'b1010101010;
        play(seq, 10, alt, -1);

        // Five dashes: full letter, no sixth element
        seq = '1;
        seq[159:150] = 10'b1010101010;
        play(seq, -1, '0, -1);

        // All slots empty
        seq = '1;
        play(seq, -1, '0, -1);

        // Reset inside the first dash
        seq = '1;
        seq[159:150] = 10'b1010101010;
        play(seq, -1, '0, 5);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 16; k++) seq[k*10 +: 10] = rand_slot();
            alt = {5{$urandom()}};
            play(seq, (r % 2 == 0) ? int'($urandom_range(2, 30)) : -1, alt, -1);
        end

`ifdef MORSE_ABORT_EN
        seq = '1;
        seq[159:150] = 10'b0110111111;
        bus.i_sequence = seq;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_pre_tone", 1, 32'(bus.tone_out), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_tone", 2, 32'(bus.tone_out), 0);
        chk("abort_done", 2, 32'(bus.done), 1);
        chk("abort_busy", 2, 32'(bus.busy), 0);
        @(negedge clk);
        chk("abort_done_single", 3, 32'(bus.done), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
